// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-port BRAM arbiter.
package bram_arb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_e;

  localparam int unsigned REQ_FETCH = 0;
  localparam int unsigned REQ_DATA  = 1;
  localparam int unsigned NUM_REQ   = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the requester rr names.
module rr_arbiter2
  import bram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               rr,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req[REQ_FETCH] && req[REQ_DATA]) begin
      gnt     = '0;
      gnt[rr] = 1'b1;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one external single-port RAM between a fetch and a data requester,
// after zeroing the whole RAM once out of reset.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_wen,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_din,
  output logic                        ram_we,
  input  logic [DATA_W-1:0]           ram_dout,
  output logic                        init_done
);

  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                rr_q, rr_d;
  logic [NUM_REQ-1:0]  pend_q, pend_d;

  logic [NUM_REQ-1:0]  gnt;
  logic                gidx;
  logic                hs;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_wen;

  rr_arbiter2 u_rr_arbiter2 (
    .req (req_valid),
    .rr  (rr_q),
    .gnt (gnt)
  );

  assign gidx      = gnt[REQ_DATA];
  assign hs        = (state_q == SERVE) && (|gnt);
  assign sel_addr  = gidx ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
  assign sel_wdata = gidx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign sel_wen   = gidx ? req_wen[REQ_DATA] : req_wen[REQ_FETCH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // CLEAR is left exactly once, after the last address has been zeroed.
  always_comb begin
    state_d = state_q;
    if ((state_q == CLEAR) && (clr_cnt_q == CLR_LAST)) begin
      state_d = SERVE;
    end
  end

  always_comb begin
    req_ready = '0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    init_done = 1'b0;
    unique case (state_q)
      CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt_q;
      end
      SERVE: begin
        init_done = 1'b1;
        req_ready = gnt;
        if (hs) begin
          ram_we   = sel_wen;
          ram_addr = sel_addr;
          ram_din  = sel_wdata;
        end
      end
    endcase
  end

  // Sweep counter, fairness pointer and one-deep read-response tracking.
  always_comb begin
    clr_cnt_d = clr_cnt_q;
    rr_d      = rr_q;
    pend_d    = '0;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
    end
    if (hs) begin
      rr_d = ~gidx;
      if (!sel_wen) begin
        pend_d = gnt;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clr_cnt_q <= '0;
      rr_q      <= 1'b0;
      pend_q    <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
      rr_q      <= rr_d;
      pend_q    <= pend_d;
    end
  end

  assign rsp_valid = pend_q;
  assign rsp_rdata = (|pend_q) ? ram_dout : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios plus random traffic
// against a shadow-memory model of the arbitration rules.
module tb_bram_port_arbiter;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_ready;
  logic [1:0]        req_wen = '0;
  logic [AW-1:0]     a_in [2];
  logic [DW-1:0]     d_in [2];
  logic [2*AW-1:0]   req_addr;
  logic [2*DW-1:0]   req_wdata;
  logic [1:0]        rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_din;
  logic              ram_we;
  logic [DW-1:0]     ram_dout = '0;
  logic              init_done;

  int checks = 0;
  int errors = 0;

  assign req_addr  = {a_in[1], a_in[0]};
  assign req_wdata = {d_in[1], d_in[0]};

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .init_done (init_done)
  );

  always #5 clock = ~clock;

  // External RAM: registered read, contents start as garbage so the sweep matters.
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom | 32'h1;
  always @(posedge clock) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_din;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req_valid = v;
    req_wen   = w;
    a_in[0]   = a0;
    a_in[1]   = a1;
    d_in[0]   = d0;
    d_in[1]   = d1;
  endtask

  // Reference model: clear-cycle count, tie preference, shadow memory, expected response.
  int unsigned   m_cnt = 0;
  bit            m_favor = 1'b0;
  logic [1:0]    m_rsp = '0;
  logic [DW-1:0] m_rsp_data = '0;
  logic [DW-1:0] shadow [DEPTH];

  initial begin
    logic [1:0]    e_ready;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    bit            serving;
    int            g;
    forever begin
      @(negedge clock);
      if (reset) begin
        m_cnt      = 0;
        m_favor    = 1'b0;
        m_rsp      = '0;
        m_rsp_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) shadow[i] = '0;
      end
      serving = (m_cnt >= DEPTH);
      e_ready = '0;
      if (serving) begin
        if (req_valid == 2'b11) e_ready = m_favor ? 2'b10 : 2'b01;
        else                    e_ready = req_valid;
      end
      g = e_ready[1] ? 1 : 0;
      if (!serving) begin
        e_we = 1'b1; e_addr = AW'(m_cnt); e_din = '0;
      end else if (e_ready != 0) begin
        e_we = req_wen[g]; e_addr = a_in[g]; e_din = d_in[g];
      end else begin
        e_we = 1'b0; e_addr = '0; e_din = '0;
      end
      check("ready",     64'(req_ready), 64'(e_ready));
      check("ram_we",    64'(ram_we),    64'(e_we));
      check("ram_addr",  64'(ram_addr),  64'(e_addr));
      check("ram_din",   64'(ram_din),   64'(e_din));
      check("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
      check("rsp_rdata", 64'(rsp_rdata), 64'(m_rsp != 0 ? m_rsp_data : '0));
      check("init_done", 64'(init_done), 64'(serving));
      if (!reset) begin
        m_rsp = '0;
        if (!serving) begin
          m_cnt++;
        end else if (e_ready != 0) begin
          if (req_wen[g]) begin
            shadow[a_in[g]] = d_in[g];
          end else begin
            m_rsp      = e_ready;
            m_rsp_data = shadow[a_in[g]];
          end
          m_favor = (g == 0);
        end
      end
    end
  end

  initial begin
    logic [1:0] prev;
    logic [1:0] exp_g;
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    drive(2'b11, 2'b00, 4'd3, 4'd4, '0, '0);

    // Clear sweep: 16 write cycles of zero, no grants even with both requesting.
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      check("sweep_addr", 64'(ram_addr), 64'(i));
      check("sweep_we",   64'(ram_we),   64'd1);
      check("sweep_rdy",  64'(req_ready), 64'd0);
      check("sweep_done", 64'(init_done), 64'd0);
      step();
      if (i == 15) drive(2'b00, 2'b00, '0, '0, '0, '0);
    end
    @(negedge clock);
    check("init_done_17", 64'(init_done), 64'd1);

    // Write then read-back on port 1.
    step(); drive(2'b10, 2'b10, '0, 4'd5, '0, 32'hDEADBEEF);
    @(negedge clock);
    check("wr5_rdy", 64'(req_ready), 64'b10);
    check("wr5_din", 64'(ram_din), 64'hDEADBEEF);
    step(); drive(2'b10, 2'b00, '0, 4'd5, '0, '0);
    @(negedge clock);
    check("rd5_rdy", 64'(req_ready), 64'b10);
    step(); drive(2'b00, 2'b00, '0, '0, '0, '0);
    @(negedge clock);
    check("rd5_rsp",  64'(rsp_valid), 64'b10);
    check("rd5_data", 64'(rsp_rdata), 64'hDEADBEEF);

    // Port 0 fills 1..3 then reads them back-to-back.
    for (int i = 1; i <= 3; i++) begin
      step(); drive(2'b01, 2'b01, AW'(i), '0, 32'h1111_0000 + 32'(i), '0);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i <= 3) drive(2'b01, 2'b00, AW'(i), '0, '0, '0);
      else        drive(2'b00, 2'b00, '0, '0, '0, '0);
      @(negedge clock);
      if (i > 1) begin
        check("b2b_rsp",  64'(rsp_valid), 64'b01);
        check("b2b_data", 64'(rsp_rdata), 64'(32'h1111_0000 + 32'(i - 1)));
      end
    end
    step();
    @(negedge clock);
    check("idle_rdata", 64'(rsp_rdata), 64'd0);

    // Port 1 write puts the tie pointer back on port 0.
    step(); drive(2'b10, 2'b10, '0, 4'd9, '0, 32'h99);
    @(negedge clock);
    check("rr_fix", 64'(req_ready), 64'b10);

    // Both reading: grants alternate starting with port 0.
    prev = '0;
    for (int k = 0; k < 6; k++) begin
      step(); drive(2'b11, 2'b00, 4'd1, 4'd5, '0, '0);
      @(negedge clock);
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      check("alt_gnt", 64'(req_ready), 64'(exp_g));
      if (k > 0) check("alt_rsp", 64'(rsp_valid), 64'(prev));
      prev = exp_g;
    end
    step(); drive(2'b00, 2'b00, '0, '0, '0, '0);
    @(negedge clock);
    check("alt_last_rsp",  64'(rsp_valid), 64'b10);
    check("alt_last_data", 64'(rsp_rdata), 64'hDEADBEEF);

    // Port 0 write wins the tie, then port 1 takes the next cycle.
    step(); drive(2'b11, 2'b01, 4'd7, 4'd5, 32'h77, '0);
    @(negedge clock);
    check("tie_p0", 64'(req_ready), 64'b01);
    check("tie_we", 64'(ram_we), 64'd1);
    step(); drive(2'b11, 2'b01, 4'd8, 4'd5, 32'h88, '0);
    @(negedge clock);
    check("tie_p1", 64'(req_ready), 64'b10);
    check("tie_addr", 64'(ram_addr), 64'd5);

    // Reset right after a read handshake drops the response and restarts the sweep.
    step(); drive(2'b01, 2'b00, 4'd1, '0, '0, '0);
    @(negedge clock);
    check("pre_rst_rdy", 64'(req_ready), 64'b01);
    step(); reset = 1'b1; drive(2'b00, 2'b00, '0, '0, '0, '0);
    @(negedge clock);
    check("rst_rsp",  64'(rsp_valid), 64'd0);
    check("rst_done", 64'(init_done), 64'd0);
    step(); step(); reset = 1'b0;
    @(negedge clock);
    check("rst_rsp2",   64'(rsp_valid), 64'd0);
    check("rst_addr0",  64'(ram_addr),  64'd0);
    check("rst_we",     64'(ram_we),    64'd1);
    repeat (16) step();
    @(negedge clock);
    check("rst_done2", 64'(init_done), 64'd1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      step();
      reset = ($urandom_range(0, 299) == 0);
      drive(2'($urandom), 2'($urandom), AW'($urandom), AW'($urandom), $urandom, $urandom);
    end
    step(); reset = 1'b0;
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning RAM address width; depth = 2^ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 32, meaning RAM data width.
REQ-003 SHALL have port clock, input, 1, the single clock for all state.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 2, per-requester request valid; index 0 = fetch, index 1 = data.
REQ-006 SHALL have port req_ready, output, 2, per-requester grant; a handshake occurs when valid and ready are both high.
REQ-007 SHALL have port req_wen, input, 2, per-requester write enable (1 = write, 0 = read).
REQ-008 SHALL have port req_addr, input, 2xADDR_W, per-requester address.
REQ-009 SHALL have port req_wdata, input, 2xDATA_W, per-requester write data.
REQ-010 SHALL have port rsp_valid, output, 2, per-requester read-data valid (one-cycle pulse).
REQ-011 SHALL have port rsp_rdata, output, DATA_W, read data shared by both requesters and qualified by rsp_valid.
REQ-012 SHALL have port ram_addr, output, ADDR_W, address to the single-port RAM.
REQ-013 SHALL have port ram_din, output, DATA_W, write data to the RAM.
REQ-014 SHALL have port ram_we, output, 1, RAM write enable.
REQ-015 SHALL have port ram_dout, input, DATA_W, RAM read data, valid one cycle after the address edge.
REQ-016 SHALL have port init_done, output, 1, high once the RAM clear sweep has completed.

Function
REQ-017 SHALL implement FSM states CLEAR and SERVE.
REQ-018 CLEAR: ram_we=1, ram_din=0, ram_addr=clr_cnt; clr_cnt increments by 1 each cycle; req_ready=00; after the cycle with clr_cnt = 2^ADDR_W-1, the FSM SHALL go to SERVE.
REQ-019 SERVE: init_done=1; the FSM SHALL never leave SERVE except on reset.
REQ-020 Grant SHALL be combinational in the same cycle: at most one req_ready bit high, and only for a requester whose req_valid is high.
REQ-021 Single requester valid: it SHALL be granted.
REQ-022 Both valid: the requester selected by the 1-bit round-robin pointer rr SHALL be granted.
REQ-023 After each handshake, rr SHALL point to the non-granted requester; with no handshake, rr SHALL hold.
REQ-024 On a handshake, ram_addr, ram_we and ram_din SHALL equal the granted requester's req_addr, req_wen and req_wdata in the same cycle.
REQ-025 With no handshake in SERVE: ram_we=0, ram_addr=0, ram_din=0.
REQ-026 A read handshake in cycle N SHALL produce rsp_valid[granted]=1 in cycle N+1, with rsp_rdata = ram_dout; read latency is exactly 1 cycle.
REQ-027 Write handshakes SHALL produce no response.
REQ-028 Back-to-back handshakes SHALL sustain one access per cycle, giving full throughput.
REQ-029 There SHALL be no response backpressure; requesters SHALL always accept rsp_valid.
REQ-030 A read of an address written in the previous cycle SHALL return the new data.
REQ-031 A write and a read of the same address in the same cycle are impossible, because only one grant exists per cycle.
REQ-032 When rsp_valid is low, rsp_rdata SHALL be 0.

Reset
REQ-033 While reset is asserted:
- state = CLEAR, clr_cnt = 0, rr = 0 (port 0 favoured).
- pending-response register cleared.
- rsp_valid = 00, init_done = 0, req_ready = 00.
REQ-034 Reset mid-operation SHALL drop any pending response (no rsp_valid after deassertion) and SHALL restart the full clear sweep.
REQ-035 All flops SHALL use the asynchronous reset, except that no reset SHALL be applied inside the RAM.

Structure
REQ-036 Shared package bram_arb_pkg SHALL hold:
- the state enum (CLEAR, SERVE);
- requester index constants REQ_FETCH=0 and REQ_DATA=1.
REQ-037 The round-robin grant logic SHALL be one sub-module, rr_arbiter2 (inputs req[1:0], rr; output gnt[1:0]).
REQ-038 The RAM itself SHALL be external and connected through the ram_* ports.

Verification
REQ-039 Reset release with ADDR_W=4: 16 cycles ram_we=1, ram_addr 0..15, ram_din=0, req_ready=00; init_done=1 on cycle 17.
REQ-040 Port 1 writes 0xDEADBEEF to address 5 in cycle N; port 1 reads address 5 in cycle N+1 -> rsp_valid=10 and rsp_rdata=0xDEADBEEF in cycle N+2.
REQ-041 Both ports hold valid reads for 6 cycles from rr=0 -> grants 0,1,0,1,0,1; each rsp_valid arrives one cycle after its grant.
REQ-042 Port 0 alone reads addresses 1,2,3 back-to-back -> three consecutive rsp_valid=01 pulses carrying the stored data.
REQ-043 Reset asserted the cycle after a read handshake -> no rsp_valid after deassertion; the clear sweep restarts at address 0.
REQ-044 Port 0 writes while port 1 is valid, with rr=0 -> port 0 granted, rr=1, port 1 granted next cycle.
